// File: rtl/cuckoo_pkg.sv
// Shared definitions for the two-table cuckoo insert controller.
package cuckoo_pkg;
  localparam int DATA_W_DEF    = 32;
  localparam int IDX_W_DEF     = 5;
  localparam int MAX_KICKS_DEF = 16;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_DUP  = 2'b01;
  localparam logic [1:0] ST_FAIL = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_PROBE, S_DONE} state_t;

  // Stored entry is {key, idx1, idx2}; the valid bit is kept separately.
  function automatic int entry_w(input int dw, input int iw);
    return dw + 2 * iw;
  endfunction
endpackage

// File: rtl/cuckoo_table.sv
// One cuckoo table: register array with valid bits, one write port,
// a probe read port, a readback port and a synchronous clear.
module cuckoo_table
  import cuckoo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IDX_W  = IDX_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_key,
  input  logic [IDX_W-1:0]  wr_idx1,
  input  logic [IDX_W-1:0]  wr_idx2,
  input  logic [IDX_W-1:0]  pr_idx,
  output logic              pr_valid,
  output logic [DATA_W-1:0] pr_key,
  output logic [IDX_W-1:0]  pr_idx1,
  output logic [IDX_W-1:0]  pr_idx2,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_key
);
  localparam int DEPTH = 2 ** IDX_W;
  localparam int EW    = entry_w(DATA_W, IDX_W);

  logic [DEPTH-1:0] valid;
  logic [EW-1:0]    mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || clr) valid <= '0;
    else if (we)    valid[wr_idx] <= 1'b1;
  end

  // Payload needs no reset; the valid bit qualifies every read.
  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= {wr_key, wr_idx1, wr_idx2};
  end

  assign pr_valid                   = valid[pr_idx];
  assign {pr_key, pr_idx1, pr_idx2} = mem[pr_idx];
  assign rd_valid                   = valid[rd_idx];
  assign rd_key                     = mem[rd_idx][EW-1 -: DATA_W];
endmodule

// File: rtl/cuckoo_insert_ctrl.sv
// Cuckoo insert sequencer: owns T1/T2, probes one slot per cycle and
// kicks occupants to their alternate slot until a hole or the kick bound.
module cuckoo_insert_ctrl
  import cuckoo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int IDX_W     = IDX_W_DEF,
  parameter int MAX_KICKS = MAX_KICKS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_key,
  input  logic [IDX_W-1:0]  req_idx1,
  input  logic [IDX_W-1:0]  req_idx2,
  input  logic              clear,
  output logic              done_valid,
  output logic [1:0]        done_status,
  output logic [IDX_W:0]    done_kicks,
  output logic [DATA_W-1:0] orphan_key,
  output logic [IDX_W+1:0]  occupancy,
  input  logic              rd_tbl,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_key
);
  localparam logic [IDX_W:0]   KMAX     = MAX_KICKS[IDX_W:0];
  localparam logic [IDX_W+1:0] OCC_FULL = {1'b1, {(IDX_W+1){1'b0}}};

  state_t              state;
  logic                side;
  logic [DATA_W-1:0]   c_key;
  logic [IDX_W-1:0]    c_idx1, c_idx2;
  logic [IDX_W:0]      kicks;

  logic                t1_v, t2_v, rd1_v, rd2_v;
  logic [DATA_W-1:0]   t1_k, t2_k, rd1_k, rd2_k;
  logic [IDX_W-1:0]    t1_i1, t1_i2, t2_i1, t2_i2;

  logic                tgt_v, dup, wr_en, tbl_clr;
  logic [DATA_W-1:0]   tgt_k;
  logic [IDX_W-1:0]    tgt_i1, tgt_i2;

  // The carry always probes its own slot for the current side, so each
  // table is addressed directly by the matching carried index.
  assign tgt_v   = side ? t2_v  : t1_v;
  assign tgt_k   = side ? t2_k  : t1_k;
  assign tgt_i1  = side ? t2_i1 : t1_i1;
  assign tgt_i2  = side ? t2_i2 : t1_i2;
  assign dup     = (kicks == '0) && ((t1_v && t1_k == c_key) || (t2_v && t2_k == c_key));
  assign wr_en   = (state == S_PROBE) && !dup && (!tgt_v || kicks != KMAX);
  assign tbl_clr = (state == S_IDLE) && clear;

  assign req_ready = !rst && (state == S_IDLE) && !clear;
  assign rd_valid  = rd_tbl ? rd2_v : rd1_v;
  assign rd_key    = rd_tbl ? rd2_k : rd1_k;

  cuckoo_table #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_t1 (
    .clk(clk), .rst(rst), .clr(tbl_clr), .we(wr_en && !side),
    .wr_idx(c_idx1), .wr_key(c_key), .wr_idx1(c_idx1), .wr_idx2(c_idx2),
    .pr_idx(c_idx1), .pr_valid(t1_v), .pr_key(t1_k), .pr_idx1(t1_i1), .pr_idx2(t1_i2),
    .rd_idx(rd_idx), .rd_valid(rd1_v), .rd_key(rd1_k)
  );

  cuckoo_table #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_t2 (
    .clk(clk), .rst(rst), .clr(tbl_clr), .we(wr_en && side),
    .wr_idx(c_idx2), .wr_key(c_key), .wr_idx1(c_idx1), .wr_idx2(c_idx2),
    .pr_idx(c_idx2), .pr_valid(t2_v), .pr_key(t2_k), .pr_idx1(t2_i1), .pr_idx2(t2_i2),
    .rd_idx(rd_idx), .rd_valid(rd2_v), .rd_key(rd2_k)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      side        <= 1'b0;
      kicks       <= '0;
      c_key       <= '0;
      c_idx1      <= '0;
      c_idx2      <= '0;
      done_valid  <= 1'b0;
      done_status <= ST_OK;
      done_kicks  <= '0;
      orphan_key  <= '0;
      occupancy   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clear) begin
            occupancy <= '0;
          end else if (req_valid) begin
            c_key  <= req_key;
            c_idx1 <= req_idx1;
            c_idx2 <= req_idx2;
            side   <= 1'b0;
            kicks  <= '0;
            state  <= S_PROBE;
          end
        end
        S_PROBE: begin
          if (dup) begin
            state       <= S_DONE;
            done_valid  <= 1'b1;
            done_status <= ST_DUP;
            done_kicks  <= kicks;
          end else if (!tgt_v) begin
            if (occupancy != OCC_FULL) occupancy <= occupancy + 1'b1;
            state       <= S_DONE;
            done_valid  <= 1'b1;
            done_status <= ST_OK;
            done_kicks  <= kicks;
          end else if (kicks == KMAX) begin
            state       <= S_DONE;
            done_valid  <= 1'b1;
            done_status <= ST_FAIL;
            done_kicks  <= kicks;
            orphan_key  <= c_key;
          end else begin
            // Evicted occupant becomes the carry and heads for the other table.
            c_key  <= tgt_k;
            c_idx1 <= tgt_i1;
            c_idx2 <= tgt_i2;
            side   <= !side;
            kicks  <= kicks + 1'b1;
          end
        end
        S_DONE: begin
          state       <= S_IDLE;
          done_valid  <= 1'b0;
          done_status <= ST_OK;
          done_kicks  <= '0;
          orphan_key  <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cuckoo_insert_ctrl.sv
// Self-checking bench: directed vectors, multi-cycle corner sequences and
// randomized inserts against a behavioural cuckoo model.
module tb_cuckoo_insert_ctrl;
  import cuckoo_pkg::*;

  localparam int DW = 32;
  localparam int IW = 5;
  localparam int NS = 32;
  localparam int MAXK = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, req_valid, clear, rd_tbl, sel;
  logic [DW-1:0] req_key;
  logic [IW-1:0] req_idx1, req_idx2, rd_idx;

  logic          rr_a, dv_a, rdv_a, rr_b, dv_b, rdv_b;
  logic [1:0]    ds_a, ds_b;
  logic [IW:0]   dk_a, dk_b;
  logic [DW-1:0] ok_a, ok_b, rdk_a, rdk_b;
  logic [IW+1:0] occ_a, occ_b;

  logic          req_ready_m, done_valid_m, rd_valid_m;
  logic [1:0]    done_status_m;
  logic [IW:0]   done_kicks_m;
  logic [DW-1:0] orphan_key_m, rd_key_m;
  logic [IW+1:0] occupancy_m;

  assign req_ready_m   = sel ? rr_b  : rr_a;
  assign done_valid_m  = sel ? dv_b  : dv_a;
  assign done_status_m = sel ? ds_b  : ds_a;
  assign done_kicks_m  = sel ? dk_b  : dk_a;
  assign orphan_key_m  = sel ? ok_b  : ok_a;
  assign occupancy_m   = sel ? occ_b : occ_a;
  assign rd_valid_m    = sel ? rdv_b : rdv_a;
  assign rd_key_m      = sel ? rdk_b : rdk_a;

  cuckoo_insert_ctrl #(.DATA_W(DW), .IDX_W(IW), .MAX_KICKS(MAXK)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(rr_a),
    .req_key(req_key), .req_idx1(req_idx1), .req_idx2(req_idx2), .clear(clear & ~sel),
    .done_valid(dv_a), .done_status(ds_a), .done_kicks(dk_a), .orphan_key(ok_a),
    .occupancy(occ_a), .rd_tbl(rd_tbl), .rd_idx(rd_idx), .rd_valid(rdv_a), .rd_key(rdk_a)
  );

  cuckoo_insert_ctrl #(.DATA_W(DW), .IDX_W(IW), .MAX_KICKS(2)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(rr_b),
    .req_key(req_key), .req_idx1(req_idx1), .req_idx2(req_idx2), .clear(clear & sel),
    .done_valid(dv_b), .done_status(ds_b), .done_kicks(dk_b), .orphan_key(ok_b),
    .occupancy(occ_b), .rd_tbl(rd_tbl), .rd_idx(rd_idx), .rd_valid(rdv_b), .rd_key(rdk_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model of dut_a's tables.
  bit            mv [2][NS];
  logic [DW-1:0] mk [2][NS];
  logic [IW-1:0] mi [2][NS][2];
  int            m_occ;

  task automatic model_clear();
    for (int t = 0; t < 2; t++)
      for (int i = 0; i < NS; i++) mv[t][i] = 1'b0;
    m_occ = 0;
  endtask

  task automatic model_insert(input logic [DW-1:0] key, input logic [IW-1:0] i1, input logic [IW-1:0] i2,
                              output logic [1:0] st, output int kk, output logic [DW-1:0] orph);
    logic [DW-1:0] ck, tk;
    logic [IW-1:0] ci [2];
    logic [IW-1:0] ti [2];
    int s;
    kk = 0;
    orph = '0;
    if ((mv[0][i1] && mk[0][i1] == key) || (mv[1][i2] && mk[1][i2] == key)) begin
      st = ST_DUP;
      return;
    end
    ck = key; ci[0] = i1; ci[1] = i2; s = 0;
    forever begin
      if (!mv[s][ci[s]]) begin
        mv[s][ci[s]] = 1'b1; mk[s][ci[s]] = ck; mi[s][ci[s]] = ci;
        if (m_occ < 2 * NS) m_occ++;
        st = ST_OK;
        return;
      end
      if (kk == MAXK) begin
        st = ST_FAIL;
        orph = ck;
        return;
      end
      tk = mk[s][ci[s]]; ti = mi[s][ci[s]];
      mk[s][ci[s]] = ck; mi[s][ci[s]] = ci;
      ck = tk; ci = ti; s = 1 - s; kk++;
    end
  endtask

  // Entered and left one time unit after a rising edge.
  task automatic do_insert(input logic [DW-1:0] key, input logic [IW-1:0] i1, input logic [IW-1:0] i2,
                           output logic [1:0] st, output int kk, output logic [DW-1:0] orph, output int lat);
    req_key = key; req_idx1 = i1; req_idx2 = i2; req_valid = 1'b1;
    #1;
    check("ready_idle", req_ready_m, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    check("ready_busy", req_ready_m, 0);
    while (!done_valid_m && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("done_seen", done_valid_m, 1);
    st = done_status_m; kk = int'(done_kicks_m); orph = orphan_key_m;
    @(posedge clk); #1;
    check("done_pulse", done_valid_m, 0);
  endtask

  task automatic run_and_check(input logic [DW-1:0] key, input logic [IW-1:0] i1, input logic [IW-1:0] i2,
                               output int kk_got);
    logic [1:0] est, st;
    int ekk, lat;
    logic [DW-1:0] eorph, orph;
    model_insert(key, i1, i2, est, ekk, eorph);
    do_insert(key, i1, i2, st, kk_got, orph, lat);
    check("status", st, est);
    check("kicks", kk_got, ekk);
    check("orphan", orph, eorph);
    check("latency", lat, 2 + ekk);
    check("occupancy", occupancy_m, m_occ);
  endtask

  task automatic rb_check(input logic t, input logic [IW-1:0] i, input bit ev, input logic [DW-1:0] ek);
    rd_tbl = t; rd_idx = i;
    #1;
    check("rd_valid", rd_valid_m, ev);
    if (ev) check("rd_key", rd_key_m, ek);
  endtask

  task automatic full_readback();
    for (int t = 0; t < 2; t++)
      for (int i = 0; i < NS; i++) rb_check(t[0], i[IW-1:0], mv[t][i], mk[t][i]);
    @(posedge clk); #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_clear();
    check("occ_clear", occupancy_m, 0);
  endtask

  typedef struct {
    bit            s;
    logic [DW-1:0] key;
    logic [IW-1:0] i1, i2;
    logic [1:0]    st;
    int            kk;
    logic [DW-1:0] orph;
    int            occ;
  } vec_t;

  vec_t vt [6];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] st;
    int kk, lat, kseen;
    logic [DW-1:0] orph, key;
    bit saw_done;

    vt[0] = '{0, 32'hA5, 5'd3, 5'd7, ST_OK,   0, 32'h0,  1};
    vt[1] = '{0, 32'hB6, 5'd3, 5'd9, ST_OK,   1, 32'h0,  2};
    vt[2] = '{0, 32'hA5, 5'd3, 5'd7, ST_DUP,  0, 32'h0,  2};
    vt[3] = '{1, 32'h11, 5'd0, 5'd0, ST_OK,   0, 32'h0,  1};
    vt[4] = '{1, 32'h22, 5'd0, 5'd0, ST_OK,   1, 32'h0,  2};
    vt[5] = '{1, 32'h33, 5'd0, 5'd0, ST_FAIL, 2, 32'h11, 2};

    rst = 1'b1; req_valid = 1'b0; clear = 1'b0; rd_tbl = 1'b0; rd_idx = '0; sel = 1'b0;
    req_key = '0; req_idx1 = '0; req_idx2 = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready_a", rr_a, 0);
    check("rst_ready_b", rr_b, 0);
    check("rst_done", {dv_a, dv_b, ds_a, dk_a, ok_a}, 0);
    check("rst_occ", {occ_a, occ_b}, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", rr_a, 1);
    @(posedge clk); #1;

    // Directed vectors (spec scenarios 1-4).
    for (int v = 0; v < 6; v++) begin
      sel = vt[v].s;
      do_insert(vt[v].key, vt[v].i1, vt[v].i2, st, kk, orph, lat);
      check("vec_status", st, vt[v].st);
      check("vec_kicks", kk, vt[v].kk);
      check("vec_orphan", orph, vt[v].orph);
      check("vec_latency", lat, 2 + vt[v].kk);
      check("vec_occ", occupancy_m, vt[v].occ);
    end
    sel = 1'b1;
    rb_check(1'b0, 5'd0, 1, 32'h33);
    rb_check(1'b1, 5'd0, 1, 32'h22);
    sel = 1'b0;
    rb_check(1'b0, 5'd3, 1, 32'hB6);
    rb_check(1'b1, 5'd7, 1, 32'hA5);
    rb_check(1'b1, 5'd9, 0, 32'h0);
    @(posedge clk); #1;

    // clear beats req_valid; request is taken the following cycle.
    clear = 1'b1; req_valid = 1'b1; req_key = 32'h77; req_idx1 = 5'd2; req_idx2 = 5'd4;
    #1;
    check("clr_ready", req_ready_m, 0);
    @(posedge clk); #1;
    clear = 1'b0;
    check("clr_occ", occupancy_m, 0);
    check("clr_busy", dv_a, 0);
    model_clear();
    rb_check(1'b0, 5'd3, 0, 32'h0);
    rb_check(1'b1, 5'd7, 0, 32'h0);
    rd_tbl = 1'b0;
    run_and_check(32'h77, 5'd2, 5'd4, kk);

    // Three-kick chain: B(4,2) C(4,5) A(1,2) then D(1,6).
    do_clear();
    run_and_check(32'hB0, 5'd4, 5'd2, kk);
    run_and_check(32'hC0, 5'd4, 5'd5, kk);
    run_and_check(32'hA0, 5'd1, 5'd2, kk);
    run_and_check(32'hD0, 5'd1, 5'd6, kseen);
    check("chain_kicks", kseen, 3);
    full_readback();

    // Same chain, reset two cycles after acceptance.
    do_clear();
    run_and_check(32'hB0, 5'd4, 5'd2, kk);
    run_and_check(32'hC0, 5'd4, 5'd5, kk);
    run_and_check(32'hA0, 5'd1, 5'd2, kk);
    req_key = 32'hD0; req_idx1 = 5'd1; req_idx2 = 5'd6; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_ready", req_ready_m, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_ready_after", req_ready_m, 1);
    check("midrst_occ", occupancy_m, 0);
    saw_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done_valid_m) saw_done = 1'b1;
    end
    check("midrst_no_done", saw_done, 0);
    model_clear();
    full_readback();

    // Randomized inserts with fixed per-key hashes.
    for (int n = 0; n < 160; n++) begin
      if ($urandom_range(0, 24) == 0) begin
        do_clear();
      end else begin
        key = DW'($urandom_range(1, 90));
        run_and_check(key, IW'((key * 7) % NS), IW'((key * 13 + 5) % NS), kk);
      end
      if (n % 40 == 39) full_readback();
    end
    full_readback();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
